mac_lane_array: RTL and testbench
=================================

Name: mac_lane_array

Overview:
- Parametrised successor to the single 8-bit multiply-accumulate unit used by the matrix-multiply datapath.
- LANES independent MAC lanes share one control FSM and one element counter.
- Operand streaming uses a valid/ready handshake; signed or unsigned operands are selectable per job.
- Each job accumulates exactly len_m1+1 products, then presents all lane sums with an output handshake.

Parameters:
DATA_W, 8, operand width per lane (bits)
LANES, 4, number of parallel MAC lanes
LEN_W, 6, element-counter width; maximum job length is 2^LEN_W products
ACC_W, 22, accumulator width per lane; the default 2*DATA_W+LEN_W is overflow-free for unsigned operands

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  job start pulse; sampled in IDLE only
len_m1  input  LEN_W  job length minus one; captured on accepted start
signed_mode  input  1  1 = two's-complement operands; captured on accepted start
clear  input  1  synchronous abort to IDLE, highest priority after reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts an operand beat
a  input  LANES*DATA_W  lane operands A; lane i uses bits [i*DATA_W +: DATA_W]
b  input  LANES*DATA_W  lane operands B, same packing as a
out_valid  output  1  acc_out holds a completed result
out_ready  input  1  downstream accepts the result
acc_out  output  LANES*ACC_W  lane sums; lane i uses bits [i*ACC_W +: ACC_W]
busy  output  1  state is not IDLE
ovf  output  LANES  per-lane sticky overflow flag (see Optional Feature)

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n. Reset drives: state=IDLE, counter=0, all accumulators=0, in_ready=0, out_valid=0, busy=0, ovf=0.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - in_ready=0.
  - start=1 captures len_m1 and signed_mode, zeroes all accumulators, counter and ovf, and moves to ACCUM on the next cycle.
- ACCUM:
  - in_ready=1.
  - A beat is accepted when in_valid&&in_ready. It adds each lane product into that lane's accumulator and increments the counter.
  - The beat where counter==len_m1 is the last beat: state moves to HOLD and out_valid=1 from the next cycle.
  - No accumulation occurs in a cycle with in_valid=0.
- HOLD:
  - in_ready=0. acc_out is stable while out_valid=1.
  - out_valid&&out_ready returns to IDLE next cycle, with out_valid=0.
  - acc_out keeps its last value until the next accepted start.
- start is ignored outside IDLE. A start in the same cycle as the HOLD handshake is ignored; IDLE must be reached first.
- clear=1 in any state forces IDLE next cycle and zeroes the accumulators, counter, out_valid and ovf. clear overrides start and any accepted beat in the same cycle.
- Arithmetic:
  - Product width is 2*DATA_W.
  - signed_mode=1: operands are two's complement; the product is sign-extended to ACC_W.
  - signed_mode=0: operands are unsigned; the product is zero-extended.
  - The accumulator adds modulo 2^ACC_W unless MAC_SAT_EN is defined.
- Latency: a single-beat job (len_m1=0) accepts its beat in the first ACCUM cycle and raises out_valid one cycle later.
- len_m1 = 2^LEN_W-1 gives the maximum job length. The counter must not wrap before the last beat.
- acc_out is a registered output with no combinational path from a or b.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined:
  - Each lane accumulator saturates instead of wrapping.
  - Signed mode clamps to the ACC_W signed range [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Unsigned mode clamps to [0, 2^ACC_W-1].
  - ovf[i] sets on any clamping event in lane i and stays set until the next accepted start, clear or reset.
- Undefined:
  - Accumulators wrap modulo 2^ACC_W.
  - ovf[i] still sets sticky on arithmetic overflow for the current mode, but results are not clamped.

Test Plan:
- Reset mid-ACCUM: assert rst_n=0 after 3 beats -> out_valid=0, in_ready=0, busy=0, acc_out=0 with no clock edge needed.
- Unsigned, LANES=4, len_m1=2, beats a=b=255 on all lanes -> acc_out lanes each 195075, out_valid one cycle after the 3rd beat.
- Signed, len_m1=1, beats (a=-128,b=127) and (a=-1,b=-1) -> each lane -16255 sign-correct in 22 bits (0x3FC081), ovf=0.
- Gaps and backpressure: in_valid toggles 1,0,0,1 with len_m1=1 -> exactly 2 accumulations; hold out_ready=0 for 5 cycles -> acc_out stable, start pulses ignored.
- clear asserted in the same cycle as the last beat -> IDLE next cycle, out_valid never rises, accumulators=0.
- ACC_W=16, MAC_SAT_EN defined, unsigned, 2 beats 255*255 -> acc_out=65535, ovf=all ones. Macro undefined -> acc_out=64514, ovf=all ones.

Source files
------------

// File: rtl/mac_lane_array.sv
// LANES-wide multiply-accumulate array: one control FSM/element counter, per-lane MAC slices.
// Optional MAC_SAT_EN: lane accumulators clamp on overflow instead of wrapping.

module mac_lane #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_sgn,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_ovf
);
  logic signed [2*DATA_W-1:0] w_ps;
  logic        [2*DATA_W-1:0] w_pu;
  logic signed [ACC_W-1:0]    w_pse;
  logic        [ACC_W-1:0]    w_pext;
  logic        [ACC_W:0]      w_sum;
  logic        [ACC_W-1:0]    w_res;
  logic        [ACC_W-1:0]    w_next;
  logic                       w_ovf_s;
  logic                       w_ovf_u;
  logic                       w_ovf;

  assign w_ps   = (2*DATA_W)'($signed(i_a)) * (2*DATA_W)'($signed(i_b));
  assign w_pu   = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);
  assign w_pse  = ACC_W'(w_ps);
  assign w_pext = i_sgn ? w_pse : ACC_W'(w_pu);
  assign w_sum  = {1'b0, o_acc} + {1'b0, w_pext};
  assign w_res  = w_sum[ACC_W-1:0];

  // Signed overflow: like-signed addends producing a result of the other sign.
  assign w_ovf_s = (o_acc[ACC_W-1] == w_pext[ACC_W-1]) && (w_res[ACC_W-1] != o_acc[ACC_W-1]);
  assign w_ovf_u = w_sum[ACC_W];
  assign w_ovf   = i_sgn ? w_ovf_s : w_ovf_u;

`ifdef MAC_SAT_EN
  logic [ACC_W-1:0] w_smax;
  logic [ACC_W-1:0] w_sat;
  assign w_smax = {1'b0, {(ACC_W-1){1'b1}}};
  assign w_sat  = !i_sgn ? {ACC_W{1'b1}} : (o_acc[ACC_W-1] ? ~w_smax : w_smax);
  assign w_next = w_ovf ? w_sat : w_res;
`else
  assign w_next = w_res;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_acc <= '0;
      o_ovf <= 1'b0;
    end else if (i_clr) begin
      o_acc <= '0;
      o_ovf <= 1'b0;
    end else if (i_en) begin
      o_acc <= w_next;
      if (w_ovf) o_ovf <= 1'b1;
    end
  end
endmodule

module mac_lane_array #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int LEN_W  = 6,
  parameter int ACC_W  = 22
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len_m1,
  input  logic                    signed_mode,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] a,
  input  logic [LANES*DATA_W-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ACC_W-1:0]  acc_out,
  output logic                    busy,
  output logic [LANES-1:0]        ovf
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_sgn;
  logic             w_start;
  logic             w_beat;
  logic             w_last;
  logic             w_lane_clr;

  assign w_start    = (r_state == IDLE) && start && !clear;
  assign w_beat     = (r_state == ACCUM) && in_valid && !clear;
  assign w_last     = (r_cnt == r_len);
  assign w_lane_clr = clear || w_start;

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == HOLD);
  assign busy      = (r_state != IDLE);

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_next = ACCUM;
        ACCUM:   if (in_valid && w_last) w_next = HOLD;
        HOLD:    if (out_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_sgn   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (clear) begin
        r_cnt <= '0;
      end else if (w_start) begin
        r_cnt <= '0;
        r_len <= len_m1;
        r_sgn <= signed_mode;
      end else if (w_beat) begin
        // Return to zero on the last beat so a max-length job never wraps mid-job.
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_lane_clr),
      .i_en  (w_beat),
      .i_sgn (r_sgn),
      .i_a   (a[i*DATA_W +: DATA_W]),
      .i_b   (b[i*DATA_W +: DATA_W]),
      .o_acc (acc_out[i*ACC_W +: ACC_W]),
      .o_ovf (ovf[i])
    );
  end
endmodule

// File: tb/tb_mac_lane_array.sv
// Directed bench for mac_lane_array: default 22-bit DUT plus a 16-bit-accumulator DUT on shared inputs.
module tb_mac_lane_array;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  len_m1 = '0;
  logic        signed_mode = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [87:0] acc_out;
  logic [3:0]  ovf;
  logic        in_ready16, out_valid16, busy16;
  logic [63:0] acc16;
  logic [3:0]  ovf16;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mac_lane_array u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_m1(len_m1), .signed_mode(signed_mode),
    .clear(clear), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .busy(busy), .ovf(ovf)
  );

  mac_lane_array #(.ACC_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len_m1(len_m1), .signed_mode(signed_mode),
    .clear(clear), .in_valid(in_valid), .in_ready(in_ready16), .a(a), .b(b),
    .out_valid(out_valid16), .out_ready(out_ready), .acc_out(acc16), .busy(busy16), .ovf(ovf16)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input logic [5:0] len, input logic sgn);
    start = 1'b1; len_m1 = len; signed_mode = sgn;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] av, input logic [7:0] bv);
    a = {4{av}}; b = {4{bv}}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: busy=%b ov=%b ir=%b exp 0", busy, out_valid, in_ready); end
    n_chk++; if (acc_out !== 88'd0 || ovf !== 4'h0) begin n_fail++; $display("FAIL reset_acc: acc=%h ovf=%h exp 0", acc_out, ovf); end
    tick(); rst_n = 1'b1; tick();
    start_job(6'd5, 1'b0);
    beat(8'd7, 8'd9); beat(8'd7, 8'd9); beat(8'd7, 8'd9);
    n_chk++; if (acc_out !== {4{22'd189}}) begin n_fail++; $display("FAIL pre_reset_acc: got %h exp %h", acc_out, {4{22'd189}}); end
    #2 rst_n = 1'b0; #1;
    n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl: busy=%b ov=%b ir=%b exp 0", busy, out_valid, in_ready); end
    n_chk++; if (acc_out !== 88'd0) begin n_fail++; $display("FAIL midreset_acc: got %h exp 0", acc_out); end
    tick(); rst_n = 1'b1; tick();
  endtask

  task automatic test_unsigned();
    start_job(6'd2, 1'b0);
    n_chk++; if (in_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL accum_ready: ir=%b busy=%b exp 1 1", in_ready, busy); end
    beat(8'd255, 8'd255); beat(8'd255, 8'd255);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL u_early_valid: got %b exp 0", out_valid); end
    beat(8'd255, 8'd255);
    n_chk++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL u_valid: ov=%b ir=%b exp 1 0", out_valid, in_ready); end
    n_chk++; if (acc_out !== {4{22'd195075}} || ovf !== 4'h0) begin n_fail++; $display("FAIL u_acc: got %h ovf %h exp %h ovf 0", acc_out, ovf, {4{22'd195075}}); end
    handshake();
    n_chk++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL u_handshake: ov=%b busy=%b exp 0 0", out_valid, busy); end
  endtask

  task automatic test_lanes_latency();
    start_job(6'd0, 1'b0);
    a = {8'd4, 8'd3, 8'd2, 8'd1}; b = {8'd8, 8'd7, 8'd6, 8'd5}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: ov=%b exp 1", out_valid); end
    n_chk++; if (acc_out !== {22'd32, 22'd21, 22'd12, 22'd5}) begin n_fail++; $display("FAIL lane_pack: got %h exp %h", acc_out, {22'd32, 22'd21, 22'd12, 22'd5}); end
    handshake();
  endtask

  task automatic test_signed();
    start_job(6'd1, 1'b1);
    beat(8'h80, 8'h7F); beat(8'hFF, 8'hFF);
    n_chk++; if (out_valid !== 1'b1 || acc_out !== {4{22'h3FC081}}) begin n_fail++; $display("FAIL s_acc: ov=%b got %h exp %h", out_valid, acc_out, {4{22'h3FC081}}); end
    n_chk++; if (ovf !== 4'h0) begin n_fail++; $display("FAIL s_ovf: got %h exp 0", ovf); end
    handshake();
  endtask

  task automatic test_gaps_backpressure();
    start_job(6'd1, 1'b0);
    beat(8'd2, 8'd2);
    tick(); tick();
    n_chk++; if (out_valid !== 1'b0 || acc_out !== {4{22'd4}}) begin n_fail++; $display("FAIL gap_noacc: ov=%b got %h exp 0 %h", out_valid, acc_out, {4{22'd4}}); end
    beat(8'd3, 8'd3);
    n_chk++; if (out_valid !== 1'b1 || acc_out !== {4{22'd13}}) begin n_fail++; $display("FAIL gap_acc: ov=%b got %h exp 1 %h", out_valid, acc_out, {4{22'd13}}); end
    for (int k = 0; k < 5; k++) begin
      start = 1'b1; in_valid = 1'b1; a = '1; b = '1;
      tick();
      n_chk++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== {4{22'd13}}) begin n_fail++; $display("FAIL hold_stable[%0d]: ov=%b ir=%b got %h exp 1 0 %h", k, out_valid, in_ready, acc_out, {4{22'd13}}); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_exit: busy=%b ov=%b exp 0 0", busy, out_valid); end
    tick();
    n_chk++; if (busy !== 1'b0 || acc_out !== {4{22'd13}}) begin n_fail++; $display("FAIL start_in_handshake: busy=%b got %h exp 0 %h", busy, acc_out, {4{22'd13}}); end
  endtask

  task automatic test_clear();
    start_job(6'd1, 1'b0);
    beat(8'd10, 8'd10);
    a = {4{8'd10}}; b = {4{8'd10}}; in_valid = 1'b1; clear = 1'b1;
    tick();
    in_valid = 1'b0; clear = 1'b0;
    n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0 || acc_out !== 88'd0) begin n_fail++; $display("FAIL clear_last: busy=%b ov=%b got %h exp 0 0 0", busy, out_valid, acc_out); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_novalid: ov=%b exp 0", out_valid); end
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_over_start: busy=%b exp 0", busy); end
  endtask

  task automatic test_max_len();
    start_job(6'd63, 1'b0);
    for (int k = 0; k < 63; k++) beat(8'd1, 8'd1);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL maxlen_early: ov=%b exp 0", out_valid); end
    beat(8'd1, 8'd1);
    n_chk++; if (out_valid !== 1'b1 || acc_out !== {4{22'd64}}) begin n_fail++; $display("FAIL maxlen_acc: ov=%b got %h exp 1 %h", out_valid, acc_out, {4{22'd64}}); end
    handshake();
  endtask

  task automatic test_overflow();
    logic [15:0] eu, es;
`ifdef MAC_SAT_EN
    eu = 16'hFFFF; es = 16'h7FFF;
`else
    eu = 16'hFC02; es = 16'h8000;
`endif
    start_job(6'd1, 1'b0);
    beat(8'd255, 8'd255); beat(8'd255, 8'd255);
    n_chk++; if (acc16 !== {4{eu}} || ovf16 !== 4'hF) begin n_fail++; $display("FAIL u16_ovf: got %h ovf %h exp %h ovf f", acc16, ovf16, {4{eu}}); end
    n_chk++; if (acc_out !== {4{22'd130050}} || ovf !== 4'h0) begin n_fail++; $display("FAIL u22_noovf: got %h ovf %h exp %h ovf 0", acc_out, ovf, {4{22'd130050}}); end
    handshake();
    start_job(6'd1, 1'b1);
    n_chk++; if (ovf16 !== 4'h0 || acc16 !== 64'd0) begin n_fail++; $display("FAIL start_clr_ovf: ovf %h acc %h exp 0 0", ovf16, acc16); end
    beat(8'h80, 8'h80); beat(8'h80, 8'h80);
    n_chk++; if (acc16 !== {4{es}} || ovf16 !== 4'hF) begin n_fail++; $display("FAIL s16_ovf: got %h ovf %h exp %h ovf f", acc16, ovf16, {4{es}}); end
    n_chk++; if (acc_out !== {4{22'd32768}} || ovf !== 4'h0) begin n_fail++; $display("FAIL s22_noovf: got %h ovf %h exp %h ovf 0", acc_out, ovf, {4{22'd32768}}); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_lanes_latency();
    test_signed();
    test_gaps_backpressure();
    test_clear();
    test_max_len();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
